// File: rtl/div_frac_dither_mc_pkg.sv
// Shared definitions for the multi-channel dithered fractional divider:
// the controller state encoding and the channel-id width helper.
package div_frac_dither_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // A channel id is always at least one bit wide, even with a single channel.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_frac_dither_mc_if.sv
// Request/result bus of the dithered divider.
// The master drives requests and accepts results; the slave is the divider.
interface div_frac_dither_mc_if
    import div_frac_dither_mc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NCH    = 4
)();

    localparam int CH_W = ch_width(NCH);

    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_by_zero;

    modport master (
        output in_valid, in_ch, dividend, divisor, out_ready,
        input  in_ready, out_valid, out_ch, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, in_ch, dividend, divisor, out_ready,
        output in_ready, out_valid, out_ch, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_frac_dither_mc_div_serial_core.sv
// Restoring unsigned divider producing one quotient bit per cycle, MSB first.
// 'done' is high during the cycle whose clock edge computes the last bit,
// so quotient/remainder are final right after that edge.
module div_serial_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] part;
    logic [DATA_W-1:0] divisor_r;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] diff;
    logic              fits;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        trial = {part, work[DATA_W-1]};
        fits  = (trial >= {1'b0, divisor_r});
        diff  = trial[DATA_W-1:0] - divisor_r;
    end

    assign done      = busy && (cnt == CNT_W'(DATA_W - 1));
    assign quotient  = work;
    assign remainder = part;

    // Load on start, then iterate exactly DATA_W steps; quotient bits fill 'work'.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            work      <= '0;
            part      <= '0;
            divisor_r <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            work      <= dividend;
            part      <= '0;
            divisor_r <= divisor;
        end else if (busy) begin
            part <= fits ? diff : trial[DATA_W-1:0];
            work <= {work[DATA_W-2:0], fits};
            cnt  <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/div_frac_dither_mc.sv
// Multi-channel fractional-rate divider: one shared serial divider plus a
// per-channel residue accumulator that dithers the quotient so its long-run
// average equals dividend/divisor exactly.
module div_frac_dither_mc
    import div_frac_dither_mc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NCH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    div_frac_dither_mc_if.slave  bus
);

    localparam int CH_W = ch_width(NCH);

    state_t            state;
    logic [CH_W-1:0]   ch_r;
    logic [DATA_W-1:0] dividend_r;
    logic [DATA_W-1:0] divisor_r;
    logic [DATA_W-1:0] acc        [NCH];
    logic [DATA_W-1:0] stored_div [NCH];

    logic              out_valid_r;
    logic [CH_W-1:0]   out_ch_r;
    logic [DATA_W-1:0] quotient_r;
    logic [DATA_W-1:0] remainder_r;
    logic              dbz_r;

    logic              accept;
    logic              core_start;
    logic              core_done;
    logic [DATA_W-1:0] core_q;
    logic [DATA_W-1:0] core_rem;

    logic              in_range;
    logic [CH_W-1:0]   idx;
    logic [DATA_W-1:0] base;
    logic [DATA_W:0]   sum;
    logic              incr;
    logic [DATA_W-1:0] acc_next;

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = out_valid_r;
    assign bus.out_ch      = out_ch_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

    assign accept     = bus.in_valid && (state == IDLE);
    assign core_start = accept && (bus.divisor != '0);

    div_serial_core #(.DATA_W(DATA_W)) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .dividend  (bus.dividend),
        .divisor   (bus.divisor),
        .done      (core_done),
        .quotient  (core_q),
        .remainder (core_rem)
    );

    // Channel ids beyond NCH only exist when NCH is not a power of two.
    if ((1 << CH_W) == NCH) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_partial_range
        localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);
        assign in_range = ({1'b0, ch_r} < NCH_L);
    end

    // Residue update: restart from zero whenever the channel's divisor changed.
    always_comb begin
        idx      = in_range ? ch_r : '0;
        base     = (divisor_r == stored_div[idx]) ? acc[idx] : '0;
        sum      = {1'b0, base} + {1'b0, core_rem};
        incr     = 1'b0;
        acc_next = sum[DATA_W-1:0];
        if (sum >= {1'b0, divisor_r}) begin
            incr     = in_range;
            acc_next = sum[DATA_W-1:0] - divisor_r;
        end
    end

    // Controller: accept, run the divider, apply the dither, hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ch_r        <= '0;
            dividend_r  <= '0;
            divisor_r   <= '0;
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ch_r       <= bus.in_ch;
                        dividend_r <= bus.dividend;
                        divisor_r  <= bus.divisor;
                        state      <= (bus.divisor == '0) ? FIX : DIV;
                    end
                end
                DIV: begin
                    if (core_done) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    out_ch_r    <= ch_r;
                    out_valid_r <= 1'b1;
                    state       <= OUT;
                    if (divisor_r == '0) begin
                        quotient_r  <= '1;
                        remainder_r <= dividend_r;
                        dbz_r       <= 1'b1;
                    end else begin
                        quotient_r  <= core_q + DATA_W'(incr);
                        remainder_r <= core_rem;
                        dbz_r       <= 1'b0;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-channel residue store; a clear overrides a coincident update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i]        <= '0;
                stored_div[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i]        <= '0;
                stored_div[i] <= '0;
            end
        end else if ((state == FIX) && (divisor_r != '0) && in_range) begin
            acc[idx]        <= acc_next;
            stored_div[idx] <= divisor_r;
        end
    end

endmodule

// File: tb/tb_div_frac_dither_mc.sv
// Self-checking bench for div_frac_dither_mc (DATA_W=8, NCH=4).
// Expected results come from a plain-arithmetic model of the dither rule.
module tb_div_frac_dither_mc;

    localparam int DATA_W = 8;
    localparam int NCH    = 4;
    localparam int CH_W   = 2;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    int checks = 0;
    int errors = 0;

    int model_acc [NCH];
    int model_div [NCH];

    div_frac_dither_mc_if #(.DATA_W(DATA_W), .NCH(NCH)) bus ();

    div_frac_dither_mc #(.DATA_W(DATA_W), .NCH(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard stop in case the controller wedges somewhere unbounded.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] dutAcc(input int ch);
        case (ch)
            0:       return dut.acc[0];
            1:       return dut.acc[1];
            2:       return dut.acc[2];
            default: return dut.acc[3];
        endcase
    endfunction

    task automatic modelClear();
        for (int i = 0; i < NCH; i++) begin
            model_acc[i] = 0;
            model_div[i] = 0;
        end
    endtask

    // Average-preserving dither: integer quotient plus a carry out of the
    // running sum of remainders, which restarts when the divisor changes.
    task automatic modelDivide(input int ch, input int a, input int b,
                               output int q, output int r, output int dz);
        if (b == 0) begin
            q  = (1 << DATA_W) - 1;
            r  = a;
            dz = 1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 0;
            if (model_div[ch] != b) model_acc[ch] = 0;
            model_acc[ch] = model_acc[ch] + r;
            model_div[ch] = b;
            if (model_acc[ch] >= b) begin
                q = q + 1;
                model_acc[ch] = model_acc[ch] - b;
            end
        end
    endtask

    // One full transaction: request, latency, result, optional stall, release.
    // Latency counts the accepting edge as edge 1.
    task automatic applyStimulus(input int ch, input int a, input int b,
                                 input int stall, input bit clr_at_fix);
        int q, r, dz, edges, exp_lat;
        @(negedge clk);
        checkOutput("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_ch    = CH_W'(ch);
        bus.dividend = a[DATA_W-1:0];
        bus.divisor  = b[DATA_W-1:0];
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        edges = 1;
        modelDivide(ch, a, b, q, r, dz);
        if (clr_at_fix) modelClear();
        exp_lat = (b == 0) ? 2 : DATA_W + 2;
        while (!bus.out_valid && edges < 40) begin
            if (clr_at_fix && edges == DATA_W + 1) clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
            edges++;
        end
        checkOutput("out_valid", bus.out_valid, 1);
        checkOutput("latency", edges, exp_lat);
        checkOutput("quotient", bus.quotient, q);
        checkOutput("remainder", bus.remainder, r);
        checkOutput("div_by_zero", bus.div_by_zero, dz);
        checkOutput("out_ch", bus.out_ch, ch);
        checkOutput("acc", dutAcc(ch), model_acc[ch]);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_ch    = CH_W'($urandom_range(0, NCH - 1));
            bus.dividend = DATA_W'($urandom);
            bus.divisor  = DATA_W'($urandom);
            @(posedge clk);
            #1;
            checkOutput("stall_in_ready", bus.in_ready, 0);
            checkOutput("stall_out_valid", bus.out_valid, 1);
            checkOutput("stall_quotient", bus.quotient, q);
            checkOutput("stall_remainder", bus.remainder, r);
            checkOutput("stall_out_ch", bus.out_ch, ch);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("release_out_valid", bus.out_valid, 0);
        checkOutput("release_in_ready", bus.in_ready, 1);
        checkOutput("release_quotient_held", bus.quotient, q);
    endtask

    initial begin
        int b;
        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ch     = '0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        modelClear();

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_quotient", bus.quotient, 0);
        checkOutput("rst_remainder", bus.remainder, 0);
        checkOutput("rst_div_by_zero", bus.div_by_zero, 0);
        checkOutput("rst_out_ch", bus.out_ch, 0);
        rst = 1'b0;

        // ch0 10/3 three times: dithered 3,3,4.
        for (int i = 0; i < 3; i++) applyStimulus(0, 10, 3, 0, 1'b0);

        // Interleaved channels stay independent.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 10, 3, 0, 1'b0);
            applyStimulus(1, 10, 4, 0, 1'b0);
        end

        // Divide by zero, then a normal request on the same channel.
        applyStimulus(2, 25, 0, 0, 1'b0);
        applyStimulus(2, 25, 7, 0, 1'b0);

        // Clear from IDLE, then a divisor change restarts the residue.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        modelClear();
        checkOutput("clr_idle_acc1", dutAcc(1), 0);
        applyStimulus(0, 10, 3, 0, 1'b0);
        applyStimulus(0, 10, 3, 0, 1'b0);
        applyStimulus(0, 10, 4, 0, 1'b0);

        // Consumer back-pressure for six cycles.
        applyStimulus(3, 200, 9, 6, 1'b0);

        // Reset in the middle of a division.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd0;
        bus.dividend = 8'd10;
        bus.divisor  = 8'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", bus.in_ready, 1);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_quotient", bus.quotient, 0);
        checkOutput("midrst_remainder", bus.remainder, 0);
        checkOutput("midrst_acc3", dutAcc(3), 0);
        @(negedge clk);
        rst = 1'b0;
        modelClear();

        // Clear coinciding with a FIX write that carries.
        applyStimulus(1, 10, 4, 0, 1'b0);
        applyStimulus(0, 10, 3, 0, 1'b0);
        applyStimulus(0, 10, 3, 0, 1'b0);
        applyStimulus(0, 10, 3, 0, 1'b1);
        applyStimulus(0, 10, 3, 0, 1'b0);
        applyStimulus(1, 10, 4, 0, 1'b0);

        // Randomized traffic with a bias toward repeated small divisors.
        for (int i = 0; i < 30; i++) begin
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
            applyStimulus($urandom_range(0, NCH - 1), $urandom_range(0, 255), b,
                          $urandom_range(0, 3), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_frac_dither_mc.md
Name: div_frac_dither_mc

Overview:
- Multi-channel fractional-rate divider with dithered quotient.
- One shared serial subtract-shift divider computes floor(dividend/divisor) for a tagged channel.
- A per-channel residue accumulator adds each remainder and bumps the quotient by 1 whenever it reaches the divisor, so the long-run average quotient per channel equals dividend/divisor exactly.
- Used by clock/baud/sample-rate generators that share one divider across NCH rate channels.

Parameters:
- DATA_W, 32, width of dividend, divisor, quotient, remainder and per-channel accumulator.
- NCH, 4, number of independent residue channels (>=1).
- CH_W, $clog2(NCH) (min 1), channel-id width (derived localparam).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- clr  in  1  synchronous clear of all channel accumulators and stored divisors
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_ch  in  CH_W  request channel id
- dividend  in  DATA_W  unsigned dividend
- divisor  in  DATA_W  unsigned divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_ch  out  CH_W  channel id of result
- quotient  out  DATA_W  dithered quotient
- remainder  out  DATA_W  raw remainder of this division
- div_by_zero  out  1  result came from a divisor==0 request

Behaviour:
- Reset: state IDLE. in_ready=1. out_valid, out_ch, quotient, remainder and div_by_zero all 0. All accumulators and stored divisors 0.
- FSM states: IDLE, DIV, FIX, OUT.
- in_ready = (state==IDLE). Only in_valid&&in_ready accepts a request.
- On accept, latch ch, dividend and divisor.
  - divisor==0 -> FIX.
  - Otherwise -> DIV with a bit counter of 0.
- DIV: restoring division, one quotient bit per cycle, MSB first, for exactly DATA_W cycles, then -> FIX.
  - Partial remainder is DATA_W+1 bits.
- FIX (1 cycle), divisor!=0:
  - If divisor differs from stored_div[ch], use base=0; else base=acc[ch].
  - sum = base + rem, computed DATA_W+1 bits wide.
  - If sum>=divisor: incr=1 and acc[ch]<=sum-divisor; else acc[ch]<=sum.
  - stored_div[ch]<=divisor. Register quotient=q+incr, remainder=rem, div_by_zero=0.
  - Invariant acc[ch]<divisor, so the DATA_W-bit acc is sufficient.
  - q+incr never overflows: incr=1 implies divisor>=2.
- FIX, divisor==0: quotient=all ones, remainder=dividend, div_by_zero=1. acc and stored_div untouched.
- FIX -> OUT with out_valid=1.
- OUT: all outputs held stable while out_ready=0. On out_ready=1: out_valid<=0, -> IDLE. Data outputs keep their last values.
- Latency, counted from the accepting edge:
  - out_valid rises DATA_W+2 edges later for a normal request.
  - out_valid rises 2 edges later when divisor==0.
  - Max throughput is one request per DATA_W+3 cycles.
- clr: any state zeroes every acc and stored_div next edge. It does not disturb an in-flight division or the FSM. If it coincides with a FIX write, clr wins (acc stays 0); quotient output still uses the computed incr.
- in_ch>=NCH when NCH is not a power of 2: request processed, accumulator ignored (incr=0, no write).
- Reset mid-operation: immediate return to the reset state. The in-flight result is lost.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/DIV/FIX/OUT, 2-bit).
  - A function computing CH_W as max(1,$clog2(NCH)).
- One natural sub-module: div_serial_core. It is the restoring DATA_W-cycle unsigned divider with start/done, quotient and remainder, and no accumulator logic.
- The top level holds the FSM, handshakes, per-channel acc/stored_div arrays and the FIX arithmetic.

Test Plan (DATA_W=8, NCH=4):
- ch0, 10/3, three times: quotients 3,3,4; remainder 1 each time; acc 1,2,0; out_valid exactly 10 edges after each accept.
- Interleave ch0 10/3 and ch1 10/4, four each: ch0 gives 3,3,4,3 and ch1 gives 2,3,2,3, showing the channels are independent.
- ch2 25/0: quotient=255, remainder=25, div_by_zero=1, out_valid 2 edges after accept; a following ch2 25/7 gives quotient 3 with acc=4.
- ch0 10/3 twice (acc=2), then ch0 10/4: acc reset due to divisor change, quotient=2, acc=2.
- out_ready held low 6 cycles in OUT: outputs stable, in_ready=0, in_valid ignored.
- Assert rst during DIV, then clr during FIX:
  - After rst: all outputs 0, in_ready=1.
  - After clr: the next ch0 10/3 result is 3 with acc 1.
